// File: rtl/jogo_sequencia_param_if.sv
// Signal bundle between the sequence-memory game core and the board/debug logic.
// The game core takes the slave side; whoever drives the buttons takes the master side.
interface jogo_sequencia_param_if #(
   parameter int N_BOTOES    = 4,
   parameter int RODADAS_MAX = 16
);
   localparam int W = $clog2(RODADAS_MAX);

   logic                iniciar;
   logic [N_BOTOES-1:0] botoes;
   logic [N_BOTOES-1:0] leds;
   logic                pronto;
   logic                ganhou;
   logic                perdeu;
   logic                db_timeout;
   logic                db_tem_jogada;
   logic [W-1:0]        db_rodada;
   logic [W-1:0]        db_contagem;
   logic [3:0]          db_estado;

   modport master (
      output iniciar, botoes,
      input  leds, pronto, ganhou, perdeu,
      input  db_timeout, db_tem_jogada, db_rodada, db_contagem, db_estado
   );

   modport slave (
      input  iniciar, botoes,
      output leds, pronto, ganhou, perdeu,
      output db_timeout, db_tem_jogada, db_rodada, db_contagem, db_estado
   );
endinterface

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game core: the player replays a stored one-hot sequence and
// appends one play per round; win after RODADAS_MAX rounds, loss on error/timeout.
module jogo_sequencia_param #(
   parameter int                  N_BOTOES       = 4,
   parameter int                  RODADAS_MAX    = 16,
   parameter int                  TIMEOUT_CICLOS = 5000,
   parameter int                  MOSTRA_CICLOS  = 1000,
   parameter logic [N_BOTOES-1:0] JOGADA_INICIAL = N_BOTOES'(1)
) (
   input  logic                  clock,
   input  logic                  reset,
   jogo_sequencia_param_if.slave bus
);
   localparam int W    = $clog2(RODADAS_MAX);
   localparam int TMAX = (TIMEOUT_CICLOS > MOSTRA_CICLOS) ? TIMEOUT_CICLOS : MOSTRA_CICLOS;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      PREPARA     = 4'd1,
      MOSTRA      = 4'd2,
      ESPERA      = 4'd3,
      COMPARA     = 4'd4,
      ESPERA_NOVA = 4'd5,
      GRAVA       = 4'd6,
      FIM_GANHOU  = 4'd7,
      FIM_PERDEU  = 4'd8
   } estado_t;

   estado_t             state_reg, state_next;
   logic [N_BOTOES-1:0] botoes_q_reg;
   logic                ativo_reg;
   logic [N_BOTOES-1:0] jogada_reg;
   logic [N_BOTOES-1:0] ram_q_reg;
   logic [W-1:0]        rodada_reg, rodada_next;
   logic [W-1:0]        contagem_reg, contagem_next;
   logic                timeout_reg, timeout_next;
   logic [TW-1:0]       timer_reg, timer_next;
   logic                tem_jogada;
   logic                timer_fim, mostra_fim;
   logic                ram_we;
   logic [W-1:0]        ram_waddr;
   logic [N_BOTOES-1:0] ram_wdata;
   logic [N_BOTOES-1:0] mem [RODADAS_MAX];

   function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // A play is the rising edge of "any button held"; holding or changing buttons
   // without releasing all of them does not produce another play.
   assign tem_jogada = (|botoes_q_reg) & ~ativo_reg;
   assign timer_fim  = (timer_reg == TW'(TIMEOUT_CICLOS - 1));
   assign mostra_fim = (timer_reg == TW'(MOSTRA_CICLOS - 1));

   always_ff @(posedge clock) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      ram_q_reg <= mem[contagem_reg];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= INICIAL;
         botoes_q_reg <= '0;
         ativo_reg    <= 1'b0;
         jogada_reg   <= '0;
         rodada_reg   <= '0;
         contagem_reg <= '0;
         timeout_reg  <= 1'b0;
         timer_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         botoes_q_reg <= bus.botoes;
         ativo_reg    <= |botoes_q_reg;
         if (tem_jogada) begin
            jogada_reg <= botoes_q_reg;
         end
         rodada_reg   <= rodada_next;
         contagem_reg <= contagem_next;
         timeout_reg  <= timeout_next;
         timer_reg    <= timer_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rodada_next   = rodada_reg;
      contagem_next = contagem_reg;
      timeout_next  = timeout_reg;
      ram_we        = 1'b0;
      ram_waddr     = rodada_reg + 1'b1;
      ram_wdata     = jogada_reg;

      case (state_reg)
         INICIAL: begin
            if (bus.iniciar) state_next = PREPARA;
         end
         PREPARA: begin
            ram_we     = 1'b1;
            ram_waddr  = '0;
            ram_wdata  = JOGADA_INICIAL;
            state_next = MOSTRA;
         end
         MOSTRA: begin
            if (mostra_fim) state_next = ESPERA;
         end
         ESPERA: begin
            if (tem_jogada) begin
               state_next = COMPARA;
            end else if (timer_fim) begin
               state_next   = FIM_PERDEU;
               timeout_next = 1'b1;
            end
         end
         COMPARA: begin
            if (!eh_one_hot(jogada_reg) || (jogada_reg != ram_q_reg)) begin
               state_next = FIM_PERDEU;
            end else if (contagem_reg != rodada_reg) begin
               contagem_next = contagem_reg + 1'b1;
               state_next    = ESPERA;
            end else if (rodada_reg == W'(RODADAS_MAX - 1)) begin
               state_next = FIM_GANHOU;
            end else begin
               state_next = ESPERA_NOVA;
            end
         end
         ESPERA_NOVA: begin
            // A multi-hot press here is simply not a new play; the timer keeps running.
            if (tem_jogada && eh_one_hot(botoes_q_reg)) begin
               state_next = GRAVA;
            end else if (timer_fim) begin
               state_next   = FIM_PERDEU;
               timeout_next = 1'b1;
            end
         end
         GRAVA: begin
            ram_we        = 1'b1;
            rodada_next   = rodada_reg + 1'b1;
            contagem_next = '0;
            state_next    = ESPERA;
         end
         FIM_GANHOU, FIM_PERDEU: begin
            if (bus.iniciar) state_next = PREPARA;
         end
         default: state_next = INICIAL;
      endcase

      // Clearing on entry to PREPARA makes the debug outputs read zero while in PREPARA.
      if (state_next == PREPARA) begin
         rodada_next   = '0;
         contagem_next = '0;
         timeout_next  = 1'b0;
      end

      if (state_next != state_reg) begin
         timer_next = '0;
      end else if (timer_reg == {TW{1'b1}}) begin
         timer_next = timer_reg;
      end else begin
         timer_next = timer_reg + 1'b1;
      end
   end

   // RAM[0] always holds JOGADA_INICIAL while showing, so the constant is shown directly.
   always_comb begin
      case (state_reg)
         MOSTRA:                       bus.leds = JOGADA_INICIAL;
         ESPERA, ESPERA_NOVA, COMPARA: bus.leds = botoes_q_reg;
         default:                      bus.leds = '0;
      endcase
   end

   assign bus.pronto        = (state_reg == FIM_GANHOU) || (state_reg == FIM_PERDEU);
   assign bus.ganhou        = (state_reg == FIM_GANHOU);
   assign bus.perdeu        = (state_reg == FIM_PERDEU);
   assign bus.db_timeout    = timeout_reg;
   assign bus.db_tem_jogada = tem_jogada;
   assign bus.db_rodada     = rodada_reg;
   assign bus.db_contagem   = contagem_reg;
   assign bus.db_estado     = state_reg;
endmodule
